snoop_bus_ctrl: RTL and testbench
=================================

Name: snoop_bus_ctrl

Overview:
- Shared snoop-bus controller directly downstream of the two per-core cache controllers.
- Takes each core's read_miss / write_miss / invalidate request and arbitrates round-robin between the cores.
- Broadcasts the block address (BOCI) and bus operation to the other core's cache via cpu_search, and sources data from that core on a snoop hit or from unified memory otherwise.
- Returns the result with a one-cycle grant pulse.

Parameters:
- MEM_TIMEOUT, 64: max cycles in MEM_RD waiting for u_rdy before aborting with bus_err.

Ports:
- clk  input  1  system clock
- rst  input  1  synchronous reset, active-high
- req_rd_miss  input  2  per-core read_miss (index = core id); level, held until grant
- req_wr_miss  input  2  per-core write_miss; level
- req_inv  input  2  per-core invalidate (S->M upgrade); level
- req_addr0  input  13  core 0 word address
- req_addr1  input  13  core 1 word address
- snp_found  input  2  per-core cpu_search_found, valid the cycle after cpu_search
- snp_data0  input  16  core 0 send_other_proc_data
- snp_data1  input  16  core 1 send_other_proc_data
- u_rdy  input  1  unified memory ready / data valid
- u_rd_data  input  16  unified memory read word
- grant  output  2  one-hot, one-cycle completion pulse to requester
- cpu_search  output  2  snoop strobe to the non-requesting core's cache
- BOCI  output  11  broadcast block address = latched addr[12:2]
- boci_word  output  2  latched addr[1:0]
- bus_op  output  2  bus_op_t of the transaction in flight
- u_re  output  1  unified memory read enable
- u_addr  output  13  unified memory address
- resp_data  output  16  data for requester, valid with grant
- bus_err  output  1  one-cycle pulse on memory timeout
- busy  output  1  high whenever state != IDLE

Behaviour:
- Reset (rst sampled high at posedge): state=IDLE; all outputs 0; rr_last=1, so core 0 wins the first tie; timeout counter=0. Reset mid-transaction aborts it silently with no grant, and requesters keep their levels.
- Request decode per core: wr_miss -> BUS_RDX; else inv -> BUS_UPGR; else rd_miss -> BUS_RD; else none. When several request bits are set, precedence is wr_miss > inv > rd_miss.
- Arbitration (IDLE only): if exactly one core requests, it wins. If both request, the core != rr_last wins. The winner's id, op and address are latched; the loser waits.
- State machine:
  - IDLE -> SNOOP when any request is present. Arbitration and latch happen in the same cycle.
  - SNOOP (1 cycle): cpu_search[other]=1, BOCI, boci_word and bus_op driven from latches. -> SNOOP_RSP.
  - SNOOP_RSP (1 cycle): sample snp_found[other].
    - BUS_UPGR -> DONE, resp_data=0, found ignored.
    - found=1 -> capture snp_data[other] into resp_data -> DONE.
    - found=0 -> MEM_RD.
  - MEM_RD: u_re=1, u_addr=latched addr. On u_rdy: capture u_rd_data -> DONE.
    - Counter increments each cycle without u_rdy. When it reaches MEM_TIMEOUT-1 with no u_rdy: bus_err pulse, resp_data=0 -> DONE.
    - u_rdy in the timeout cycle wins; bus_err stays 0.
  - DONE (1 cycle): grant[id]=1, resp_data held; rr_last<=id; counter cleared. -> IDLE.
- BOCI, boci_word and bus_op stay valid from SNOOP through DONE and are 0 in IDLE.
- Latency with no memory wait: request at cycle 0 -> grant at cycle 3 (IDLE, SNOOP, SNOOP_RSP, DONE). Memory path: 4 + cycles until u_rdy.
- A core dropping its request mid-transaction has no effect; the transaction completes.
- A new request is only accepted in IDLE, so at most one transaction is in flight and back-to-back transactions have one IDLE cycle between them.
- u_re is never asserted outside MEM_RD.

Decomposition:
- Package common gains:
  - bus_op_t enum {BUS_NONE, BUS_RD, BUS_RDX, BUS_UPGR} (2 bits)
  - snoop_state_t {IDLE, SNOOP, SNOOP_RSP, MEM_RD, DONE}
  - localparam NUM_CORES=2
- One sub-module: rr_arb2. Inputs req[1:0] and rr_last; output one-hot gnt[1:0]. Purely combinational.

Test Plan:
- Core 0 rd_miss, addr=13'h0A5, snp_found[1]=1, snp_data1=16'hBEEF -> cpu_search=2'b10, BOCI=11'h029 in cycle 1; grant=2'b01 and resp_data=16'hBEEF in cycle 3; u_re never high.
- Core 1 wr_miss, addr=13'h1FF, snp_found[0]=0, u_rdy raised 5 cycles into MEM_RD with u_rd_data=16'h1234 -> bus_op=BUS_RDX, u_addr=13'h1FF, grant=2'b10 and resp_data=16'h1234 the cycle after u_rdy.
- Both cores assert rd_miss in the same cycle after reset -> core 0 granted first; core 1 granted in the next transaction (rr_last=0); grant never 2'b11.
- Core 0 asserts inv and rd_miss together -> bus_op=BUS_UPGR; no MEM_RD entry; grant at cycle 3 with resp_data=0.
- MEM_TIMEOUT=8, u_rdy held low -> bus_err one-cycle pulse, grant pulse in the same DONE cycle, back to IDLE.
- rst high during MEM_RD -> next cycle state=IDLE, u_re=0, grant=0, busy=0; the pending request is re-arbitrated after rst drops.

Source files
------------

// File: rtl/snoop_bus_ctrl_pkg.sv
`default_nettype none
// ---------------------------------------------------------------------------
// | Module   : snoop_bus_ctrl_pkg                                           |
// | Brief    : Shared types for the two-core snoop bus controller           |
// | Revision : 1.0 - initial release                                        |
// ---------------------------------------------------------------------------
package snoop_bus_ctrl_pkg;

  localparam int NUM_CORES = 2;

  typedef enum logic [1:0] {
    BUS_NONE = 2'd0,
    BUS_RD   = 2'd1,
    BUS_RDX  = 2'd2,
    BUS_UPGR = 2'd3
  } bus_op_t;

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    SNOOP     = 3'd1,
    SNOOP_RSP = 3'd2,
    MEM_RD    = 3'd3,
    DONE      = 3'd4
  } snoop_state_t;

  // Map a core's request lines to a bus operation; write miss dominates,
  // then upgrade, then plain read miss.
  function automatic bus_op_t decode_op(input logic wr, input logic inv, input logic rd);
    bus_op_t op;
    op = BUS_NONE;
    if (wr) begin
      op = BUS_RDX;
    end else if (inv) begin
      op = BUS_UPGR;
    end else if (rd) begin
      op = BUS_RD;
    end
    return op;
  endfunction

endpackage
`default_nettype wire

// File: rtl/snoop_bus_ctrl_rr_arb2.sv
`default_nettype none
// ---------------------------------------------------------------------------
// | Module   : rr_arb2                                                      |
// | Brief    : Two-requester round-robin arbiter, purely combinational      |
// | Revision : 1.0 - initial release                                        |
// ---------------------------------------------------------------------------
module rr_arb2
  import snoop_bus_ctrl_pkg::*;
(
  input  logic [NUM_CORES-1:0] req,
  input  logic                 rr_last,
  output logic [NUM_CORES-1:0] gnt
);

  // A lone requester wins outright; on a tie the core that did not win last goes.
  always_comb begin
    gnt = req;
    if (req == 2'b11) begin
      gnt = rr_last ? 2'b01 : 2'b10;
    end
  end

endmodule
`default_nettype wire

// File: rtl/snoop_bus_ctrl.sv
`default_nettype none
// ---------------------------------------------------------------------------
// | Module   : snoop_bus_ctrl                                               |
// | Brief    : Shared snoop bus controller: arbitrates the two cores,       |
// |            snoops the other cache, falls back to unified memory         |
// | Revision : 1.0 - initial release                                        |
// ---------------------------------------------------------------------------
module snoop_bus_ctrl
  import snoop_bus_ctrl_pkg::*;
#(
  parameter int MEM_TIMEOUT = 64
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [1:0]  req_rd_miss,
  input  logic [1:0]  req_wr_miss,
  input  logic [1:0]  req_inv,
  input  logic [12:0] req_addr0,
  input  logic [12:0] req_addr1,
  input  logic [1:0]  snp_found,
  input  logic [15:0] snp_data0,
  input  logic [15:0] snp_data1,
  input  logic        u_rdy,
  input  logic [15:0] u_rd_data,
  output logic [1:0]  grant,
  output logic [1:0]  cpu_search,
  output logic [10:0] BOCI,
  output logic [1:0]  boci_word,
  output logic [1:0]  bus_op,
  output logic        u_re,
  output logic [12:0] u_addr,
  output logic [15:0] resp_data,
  output logic        bus_err,
  output logic        busy
);

  localparam int                c_cnt_w    = (MEM_TIMEOUT > 1) ? $clog2(MEM_TIMEOUT) : 1;
  localparam logic [c_cnt_w-1:0] c_cnt_last = c_cnt_w'(MEM_TIMEOUT - 1);

  snoop_state_t         r_state, w_next_state;
  logic                 r_id;
  bus_op_t              r_op;
  logic [12:0]          r_addr;
  logic [15:0]          r_resp;
  logic                 r_err;
  logic [c_cnt_w-1:0]   r_cnt;
  logic                 r_rr_last;

  logic [1:0]           w_req_any;
  logic [1:0]           w_gnt;
  logic                 w_win;
  logic                 w_found_other;
  logic [15:0]          w_other_data;
  logic                 w_timeout;

  assign w_req_any     = req_wr_miss | req_inv | req_rd_miss;
  assign w_win         = w_gnt[1];
  // The snoop target is always the core that did not issue the request.
  assign w_found_other = r_id ? snp_found[0] : snp_found[1];
  assign w_other_data  = r_id ? snp_data0 : snp_data1;
  assign w_timeout     = (r_cnt == c_cnt_last) && !u_rdy;
  assign resp_data     = r_resp;

  rr_arb2 u_arb (
    .req     (w_req_any),
    .rr_last (r_rr_last),
    .gnt     (w_gnt)
  );

  // State register.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  // Next-state decode and bus/memory output drive.
  always_comb begin
    w_next_state = r_state;
    grant        = 2'b00;
    cpu_search   = 2'b00;
    BOCI         = 11'd0;
    boci_word    = 2'b00;
    bus_op       = BUS_NONE;
    u_re         = 1'b0;
    u_addr       = 13'd0;
    bus_err      = 1'b0;
    busy         = (r_state != IDLE);
    if (r_state != IDLE) begin
      BOCI      = r_addr[12:2];
      boci_word = r_addr[1:0];
      bus_op    = r_op;
    end
    case (r_state)
      IDLE: begin
        if (|w_req_any) begin
          w_next_state = SNOOP;
        end
      end
      SNOOP: begin
        cpu_search   = r_id ? 2'b01 : 2'b10;
        w_next_state = SNOOP_RSP;
      end
      SNOOP_RSP: begin
        if ((r_op == BUS_UPGR) || w_found_other) begin
          w_next_state = DONE;
        end else begin
          w_next_state = MEM_RD;
        end
      end
      MEM_RD: begin
        u_re   = 1'b1;
        u_addr = r_addr;
        if (u_rdy || w_timeout) begin
          w_next_state = DONE;
        end
      end
      DONE: begin
        grant        = r_id ? 2'b10 : 2'b01;
        bus_err      = r_err;
        w_next_state = IDLE;
      end
      default: w_next_state = IDLE;
    endcase
  end

  // Transaction latches, response capture, timeout counter and fairness pointer.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_id      <= 1'b0;
      r_op      <= BUS_NONE;
      r_addr    <= 13'd0;
      r_resp    <= 16'd0;
      r_err     <= 1'b0;
      r_cnt     <= '0;
      r_rr_last <= 1'b1;
    end else begin
      case (r_state)
        IDLE: begin
          if (|w_req_any) begin
            r_id   <= w_win;
            r_op   <= decode_op(req_wr_miss[w_win], req_inv[w_win], req_rd_miss[w_win]);
            r_addr <= w_win ? req_addr1 : req_addr0;
            r_err  <= 1'b0;
            r_cnt  <= '0;
          end
        end
        SNOOP_RSP: begin
          if (r_op == BUS_UPGR) begin
            r_resp <= 16'd0;
          end else if (w_found_other) begin
            r_resp <= w_other_data;
          end
        end
        MEM_RD: begin
          if (u_rdy) begin
            r_resp <= u_rd_data;
          end else if (r_cnt == c_cnt_last) begin
            r_resp <= 16'd0;
            r_err  <= 1'b1;
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        DONE: begin
          r_rr_last <= r_id;
          r_cnt     <= '0;
          r_err     <= 1'b0;
        end
        default: ;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_snoop_bus_ctrl.sv
`default_nettype none
// ---------------------------------------------------------------------------
// | Module   : tb_snoop_bus_ctrl                                            |
// | Brief    : Self-checking bench for snoop_bus_ctrl with a transaction-   |
// |            level reference model                                        |
// | Revision : 1.0 - initial release                                        |
// ---------------------------------------------------------------------------
module tb_snoop_bus_ctrl;
  import snoop_bus_ctrl_pkg::*;

  localparam int TMO = 8;

  logic        clk = 1'b0;
  logic        rst;
  logic [1:0]  req_rd_miss, req_wr_miss, req_inv;
  logic [12:0] req_addr0, req_addr1;
  logic [1:0]  snp_found;
  logic [15:0] snp_data0, snp_data1;
  logic        u_rdy;
  logic [15:0] u_rd_data;
  logic [1:0]  grant, cpu_search, boci_word, bus_op;
  logic [10:0] BOCI;
  logic        u_re, bus_err, busy;
  logic [12:0] u_addr;
  logic [15:0] resp_data;

  always #5 clk = ~clk;

  snoop_bus_ctrl #(.MEM_TIMEOUT(TMO)) dut (
    .clk(clk), .rst(rst),
    .req_rd_miss(req_rd_miss), .req_wr_miss(req_wr_miss), .req_inv(req_inv),
    .req_addr0(req_addr0), .req_addr1(req_addr1),
    .snp_found(snp_found), .snp_data0(snp_data0), .snp_data1(snp_data1),
    .u_rdy(u_rdy), .u_rd_data(u_rd_data),
    .grant(grant), .cpu_search(cpu_search), .BOCI(BOCI), .boci_word(boci_word),
    .bus_op(bus_op), .u_re(u_re), .u_addr(u_addr), .resp_data(resp_data),
    .bus_err(bus_err), .busy(busy)
  );

  int n_checks = 0;
  int n_pass   = 0;

  // Pending request per core, held until that core is granted.
  bit          p_wr[2], p_inv[2], p_rd[2];
  logic [12:0] p_addr[2];
  int          m_rr_last;
  // Environment for the transaction in flight.
  logic [1:0]  t_found;
  logic [15:0] t_sd0, t_sd1, t_ud;
  int          t_delay;

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h (t=%0t)", tag, obs, exp, $time);
  endtask

  function automatic logic [31:0] pack_ctl(input logic b, input logic [1:0] cs, input logic [1:0] op,
                                           input logic [10:0] bo, input logic [1:0] bw,
                                           input logic ure, input logic [1:0] gr, input logic err);
    return {10'd0, b, cs, op, bo, bw, ure, gr, err};
  endfunction

  function automatic logic [31:0] dut_ctl();
    return pack_ctl(busy, cpu_search, bus_op, BOCI, boci_word, u_re, grant, bus_err);
  endfunction

  function automatic bit has_pending(input int c);
    return p_wr[c] | p_inv[c] | p_rd[c];
  endfunction

  task automatic drive_reqs();
    req_wr_miss = {p_wr[1], p_wr[0]};
    req_inv     = {p_inv[1], p_inv[0]};
    req_rd_miss = {p_rd[1], p_rd[0]};
    req_addr0   = p_addr[0];
    req_addr1   = p_addr[1];
  endtask

  task automatic drive_env();
    snp_found = t_found;
    snp_data0 = t_sd0;
    snp_data1 = t_sd1;
    u_rd_data = t_ud;
    u_rdy     = 1'b0;
  endtask

  task automatic clear_core(input int c);
    p_wr[c] = 0; p_inv[c] = 0; p_rd[c] = 0;
  endtask

  // Called at the negedge of the IDLE cycle in which the requests are visible.
  task automatic run_txn();
    int          win, other, lat;
    bus_op_t     op;
    logic [12:0] a;
    logic        mem, err, drop;
    logic [15:0] resp;
    if (has_pending(0) && has_pending(1)) win = (m_rr_last == 1) ? 0 : 1;
    else win = has_pending(1) ? 1 : 0;
    other = 1 - win;
    op = p_wr[win] ? BUS_RDX : p_inv[win] ? BUS_UPGR : BUS_RD;
    a = p_addr[win];
    mem = 1'b0; err = 1'b0;
    if (op == BUS_UPGR) begin
      lat = 3; resp = 16'd0;
    end else if (t_found[other]) begin
      lat = 3; resp = (other == 1) ? t_sd1 : t_sd0;
    end else if (t_delay <= TMO - 1) begin
      mem = 1'b1; lat = 4 + t_delay; resp = t_ud;
    end else begin
      mem = 1'b1; lat = 3 + TMO; resp = 16'd0; err = 1'b1;
    end
    drop = 1'($urandom_range(0, 1));
    for (int c = 1; c <= lat; c++) begin
      @(posedge clk);
      @(negedge clk);
      check_val("ctl", dut_ctl(),
                pack_ctl(1'b1, (c == 1) ? ((other == 1) ? 2'b10 : 2'b01) : 2'b00, op, a[12:2], a[1:0],
                         mem && (c >= 3) && (c < lat),
                         (c == lat) ? ((win == 1) ? 2'b10 : 2'b01) : 2'b00,
                         (c == lat) && err));
      if (mem && (c >= 3) && (c < lat)) check_val("u_addr", 32'(u_addr), 32'(a));
      if (c == lat) check_val("resp", 32'(resp_data), 32'(resp));
      u_rdy = mem && (c == 3 + t_delay);
      if ((c == 1 && drop) || c == lat) begin
        clear_core(win);
        if (c == 1) p_addr[win] = 13'($urandom);
        drive_reqs();
      end
    end
    m_rr_last = win;
  endtask

  // Advance into the IDLE cycle, confirm it is quiet, present requests, run.
  task automatic go();
    @(posedge clk);
    @(negedge clk);
    check_val("idle_ctl", dut_ctl(), 32'd0);
    drive_reqs();
    drive_env();
    run_txn();
  endtask

  task automatic rand_txn();
    logic [2:0] bits;
    for (int c = 0; c < 2; c++) begin
      if (!has_pending(c) && $urandom_range(0, 1) == 1) begin
        bits = 3'($urandom_range(1, 7));
        p_wr[c] = bits[2]; p_inv[c] = bits[1]; p_rd[c] = bits[0];
        p_addr[c] = 13'($urandom);
      end
    end
    if (!has_pending(0) && !has_pending(1)) begin
      p_rd[0] = 1; p_addr[0] = 13'($urandom);
    end
    t_found = 2'($urandom);
    t_sd0 = 16'($urandom); t_sd1 = 16'($urandom); t_ud = 16'($urandom);
    t_delay = int'($urandom_range(0, TMO + 2));
    go();
  endtask

  initial begin
    rst = 1'b1;
    for (int c = 0; c < 2; c++) begin clear_core(c); p_addr[c] = 13'd0; end
    t_found = 2'b00; t_sd0 = 16'd0; t_sd1 = 16'd0; t_ud = 16'd0; t_delay = 0;
    drive_reqs();
    drive_env();
    m_rr_last = 1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_val("rst_ctl", dut_ctl(), 32'd0);
    check_val("rst_resp", 32'(resp_data), 32'd0);
    rst = 1'b0;

    // Core 0 read miss hits in core 1's cache.
    p_rd[0] = 1; p_addr[0] = 13'h0A5;
    t_found = 2'b10; t_sd1 = 16'hBEEF; t_delay = 0;
    go();
    // Core 1 write miss served from memory after five wait cycles.
    p_wr[1] = 1; p_addr[1] = 13'h1FF;
    t_found = 2'b00; t_ud = 16'h1234; t_delay = 5;
    go();
    // Simultaneous read misses: core 0 first, then core 1.
    p_rd[0] = 1; p_addr[0] = 13'h011; p_rd[1] = 1; p_addr[1] = 13'h1C2;
    t_found = 2'b11; t_sd0 = 16'hA0A0; t_sd1 = 16'hB1B1;
    go();
    t_found = 2'b01; t_sd0 = 16'hC2C2;
    go();
    // Upgrade wins over read miss and never touches memory.
    p_inv[0] = 1; p_rd[0] = 1; p_addr[0] = 13'h777;
    t_found = 2'b10; t_sd1 = 16'h5555;
    go();
    // Memory timeout, then u_rdy arriving exactly in the timeout cycle.
    p_rd[1] = 1; p_addr[1] = 13'h0F0;
    t_found = 2'b00; t_ud = 16'h9999; t_delay = TMO + 2;
    go();
    p_rd[0] = 1; p_addr[0] = 13'h0F4;
    t_found = 2'b00; t_ud = 16'h4242; t_delay = TMO - 1;
    go();

    for (int i = 0; i < 80; i++) rand_txn();

    // Reset while waiting on memory, then re-arbitrate the held request.
    @(posedge clk);
    @(negedge clk);
    for (int c = 0; c < 2; c++) clear_core(c);
    p_rd[1] = 1; p_addr[1] = 13'h123;
    t_found = 2'b00; t_delay = 40;
    drive_reqs();
    drive_env();
    repeat (4) @(posedge clk);
    @(negedge clk);
    check_val("memrd_ure", 32'(u_re), 32'd1);
    rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    check_val("abort_ctl", dut_ctl(), 32'd0);
    check_val("abort_resp", 32'(resp_data), 32'd0);
    rst = 1'b0;
    m_rr_last = 1;
    t_found = 2'b01; t_sd0 = 16'hCAFE; t_delay = 0;
    drive_env();
    run_txn();
    @(posedge clk);
    @(negedge clk);
    check_val("final_idle", dut_ctl(), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
`default_nettype wire
